seven_seg_demux: RTL and testbench

SEVEN_SEG_DEMUX -- requirements
Module: seven_seg_demux

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seg7_to_hex.sv | 22 ++
 rtl/seven_seg_demux.sv | 120 ++++++++++++
 tb/tb_seven_seg_demux.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment demultiplexer: glyph table,
// nominal strobe spacing and the capture FSM state type.
package seven_seg_pkg;

  localparam int FREQ_DEFAULT = 12500;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  // Canonical gfedcba patterns; index n holds the glyph for hex digit n.
  localparam logic [15:0][6:0] GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational glyph decoder: a canonical pattern yields its hex value
// with ok=1, anything else yields 0 with ok=0.
module seg7_to_hex
  import seven_seg_pkg::*;
(
  input  logic [6:0] glyph,
  output logic [3:0] hex,
  output logic       ok
);

  always_comb begin
    hex = 4'd0;
    ok  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (glyph == GLYPH[i]) begin
        hex = 4'(i);
        ok  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_demux.sv
// Rebuilds a high/low digit pair from a strobed, multiplexed segment bus and
// tracks link health (lock, staleness, too-fast strobes).
module seven_seg_demux
  import seven_seg_pkg::*;
#(
  parameter int FREQ    = FREQ_DEFAULT,
  parameter int TIMEOUT = 25002,
  parameter int CBITS   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segment,
  input  logic        sig,
  output logic [13:0] both7seg,
  output logic [3:0]  hex_hi,
  output logic [3:0]  hex_lo,
  output logic        ok_hi,
  output logic        ok_lo,
  output logic        frame,
  output logic        locked,
  output logic        stale,
  output logic        err_fast
);

  state_t             state_reg, state_next;
  logic [CBITS-1:0]   gap_reg, gap_next;
  logic [13:0]        both_reg, both_next;
  logic               frame_reg, frame_next;
  logic               locked_reg, locked_next;
  logic               stale_reg, stale_next;
  logic               err_fast_reg, err_fast_next;
  logic               seen_reg, seen_next;
  logic               timeout_hit;

  assign timeout_hit = (gap_reg == CBITS'(TIMEOUT));

  always_comb begin
    state_next    = state_reg;
    gap_next      = gap_reg;
    both_next     = both_reg;
    frame_next    = 1'b0;
    locked_next   = locked_reg;
    stale_next    = stale_reg;
    err_fast_next = err_fast_reg;
    seen_next     = seen_reg;
    if (sig) begin
      // A strobe always wins over a coincident timeout.
      gap_next   = '0;
      stale_next = 1'b0;
      seen_next  = 1'b1;
      if (seen_reg && (gap_reg < CBITS'(FREQ)))
        err_fast_next = 1'b1;
      case (state_reg)
        WAIT_HI: begin
          both_next[13:7] = segment;
          state_next      = WAIT_LO;
        end
        default: begin
          both_next[6:0] = segment;
          frame_next     = 1'b1;
          locked_next    = 1'b1;
          state_next     = WAIT_HI;
        end
      endcase
    end else if (timeout_hit) begin
      stale_next  = 1'b1;
      locked_next = 1'b0;
      state_next  = WAIT_HI;
    end else begin
      gap_next = gap_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= WAIT_HI;
      gap_reg      <= '0;
      both_reg     <= '0;
      frame_reg    <= 1'b0;
      locked_reg   <= 1'b0;
      stale_reg    <= 1'b0;
      err_fast_reg <= 1'b0;
      seen_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gap_reg      <= gap_next;
      both_reg     <= both_next;
      frame_reg    <= frame_next;
      locked_reg   <= locked_next;
      stale_reg    <= stale_next;
      err_fast_reg <= err_fast_next;
      seen_reg     <= seen_next;
    end
  end

  logic [1:0][3:0] hex_w;
  logic [1:0]      ok_w;

  // Digit 1 is the high slot, digit 0 the low slot.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      seg7_to_hex u_dec (
        .glyph (both_reg[gi*7 +: 7]),
        .hex   (hex_w[gi]),
        .ok    (ok_w[gi])
      );
    end
  endgenerate

  assign both7seg = both_reg;
  assign hex_hi   = hex_w[1];
  assign hex_lo   = hex_w[0];
  assign ok_hi    = ok_w[1];
  assign ok_lo    = ok_w[0];
  assign frame    = frame_reg;
  assign locked   = locked_reg;
  assign stale    = stale_reg;
  assign err_fast = err_fast_reg;

endmodule

// File: tb/tb_seven_seg_demux.sv
// Directed bench for seven_seg_demux with default parameters; inputs change
// and outputs are sampled on the falling clock edge.
module tb_seven_seg_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  segment;
  logic        sig;
  logic [13:0] both7seg;
  logic [3:0]  hex_hi, hex_lo;
  logic        ok_hi, ok_lo, frame, locked, stale, err_fast;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seven_seg_demux dut (
    .clk      (clk),
    .rst      (rst),
    .segment  (segment),
    .sig      (sig),
    .both7seg (both7seg),
    .hex_hi   (hex_hi),
    .hex_lo   (hex_lo),
    .ok_hi    (ok_hi),
    .ok_lo    (ok_lo),
    .frame    (frame),
    .locked   (locked),
    .stale    (stale),
    .err_fast (err_fast)
  );

  // One-cycle strobe; returns on the falling edge after the capturing edge.
  task automatic strobe(input logic [6:0] s);
    @(negedge clk);
    sig     = 1'b1;
    segment = s;
    @(negedge clk);
    sig     = 1'b0;
    segment = 7'h55;
    $display("[TB] strobe seg=%02h -> both7seg=%04h hex=%h/%h ok=%b/%b frame=%b locked=%b stale=%b err_fast=%b",
             s, both7seg, hex_hi, hex_lo, ok_hi, ok_lo, frame, locked, stale, err_fast);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sig = 1'b0; segment = 7'h00;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({both7seg, hex_hi, hex_lo, ok_hi, ok_lo, frame, locked, stale, err_fast} !== 30'd0) begin
      tests_failed++;
      $display("FAIL reset_values: both7seg=%04h hex=%h/%h ok=%b/%b frame=%b locked=%b stale=%b err_fast=%b, required all zero",
               both7seg, hex_hi, hex_lo, ok_hi, ok_lo, frame, locked, stale, err_fast);
    end
  endtask

  task automatic test_pair();
    strobe(7'h06);
    tests_run++;
    if (both7seg !== 14'h0300 || frame !== 1'b0 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL pair_high: both7seg=%04h frame=%b locked=%b, required 0300 0 0", both7seg, frame, locked);
    end
    idle(12499);
    strobe(7'h5B);
    tests_run++;
    if (both7seg !== 14'h035B || hex_hi !== 4'h1 || hex_lo !== 4'h2 || ok_hi !== 1'b1 || ok_lo !== 1'b1) begin
      tests_failed++;
      $display("FAIL pair_data: both7seg=%04h hex=%h/%h ok=%b/%b, required 035B 1/2 1/1", both7seg, hex_hi, hex_lo, ok_hi, ok_lo);
    end
    tests_run++;
    if (frame !== 1'b1 || locked !== 1'b1 || err_fast !== 1'b0 || stale !== 1'b0) begin
      tests_failed++;
      $display("FAIL pair_flags: frame=%b locked=%b err_fast=%b stale=%b, required 1 1 0 0", frame, locked, err_fast, stale);
    end
    @(negedge clk);
    tests_run++;
    if (frame !== 1'b0 || both7seg !== 14'h035B) begin
      tests_failed++;
      $display("FAIL pair_single_pulse: frame=%b both7seg=%04h, required 0 035B", frame, both7seg);
    end
  endtask

  task automatic test_stale();
    idle(12498);
    strobe(7'h7F);
    idle(25000);
    tests_run++;
    if (stale !== 1'b0 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL stale_early: stale=%b locked=%b, required 0 1", stale, locked);
    end
    idle(3);
    tests_run++;
    if (stale !== 1'b1 || locked !== 1'b0 || both7seg[13:7] !== 7'h7F || err_fast !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_set: stale=%b locked=%b hi=%02h err_fast=%b, required 1 0 7F 0", stale, locked, both7seg[13:7], err_fast);
    end
    strobe(7'h3F);
    tests_run++;
    if (stale !== 1'b0 || frame !== 1'b0 || both7seg !== 14'h1FDB) begin
      tests_failed++;
      $display("FAIL stale_recover: stale=%b frame=%b both7seg=%04h, required 0 0 1FDB", stale, frame, both7seg);
    end
  endtask

  task automatic test_bad_glyph();
    idle(12499);
    strobe(7'h00);
    tests_run++;
    if (ok_lo !== 1'b0 || hex_lo !== 4'h0 || frame !== 1'b1 || ok_hi !== 1'b1 || hex_hi !== 4'h0 || both7seg !== 14'h1F80) begin
      tests_failed++;
      $display("FAIL bad_glyph: ok_lo=%b hex_lo=%h frame=%b ok_hi=%b hex_hi=%h both7seg=%04h, required 0 0 1 1 0 1F80",
               ok_lo, hex_lo, frame, ok_hi, hex_hi, both7seg);
    end
    tests_run++;
    if (locked !== 1'b1 || err_fast !== 1'b0) begin
      tests_failed++;
      $display("FAIL bad_glyph_flags: locked=%b err_fast=%b, required 1 0", locked, err_fast);
    end
  endtask

  task automatic test_err_fast();
    idle(12499);
    strobe(7'h66);
    tests_run++;
    if (err_fast !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_fast_nominal: err_fast=%b, required 0", err_fast);
    end
    idle(98);
    strobe(7'h6D);
    tests_run++;
    if (err_fast !== 1'b1 || frame !== 1'b1 || both7seg !== 14'h336D) begin
      tests_failed++;
      $display("FAIL err_fast_set: err_fast=%b frame=%b both7seg=%04h, required 1 1 336D", err_fast, frame, both7seg);
    end
    idle(20);
    strobe(7'h7D);
    idle(12499);
    strobe(7'h07);
    tests_run++;
    if (err_fast !== 1'b1 || both7seg !== 14'h3E87) begin
      tests_failed++;
      $display("FAIL err_fast_sticky: err_fast=%b both7seg=%04h, required 1 3E87", err_fast, both7seg);
    end
  endtask

  task automatic test_reset_mid();
    strobe(7'h66);
    rst = 1'b1; sig = 1'b1; segment = 7'h6D;
    @(negedge clk);
    rst = 1'b0; sig = 1'b0;
    tests_run++;
    if ({both7seg, hex_hi, hex_lo, ok_hi, ok_lo, frame, locked, stale, err_fast} !== 30'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: both7seg=%04h hex=%h/%h ok=%b/%b frame=%b locked=%b stale=%b err_fast=%b, required all zero",
               both7seg, hex_hi, hex_lo, ok_hi, ok_lo, frame, locked, stale, err_fast);
    end
    strobe(7'h4F);
    tests_run++;
    if (both7seg !== 14'h2780 || frame !== 1'b0 || err_fast !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_high: both7seg=%04h frame=%b err_fast=%b, required 2780 0 0", both7seg, frame, err_fast);
    end
    idle(12499);
    strobe(7'h07);
    tests_run++;
    if (both7seg !== 14'h2787 || hex_hi !== 4'h3 || hex_lo !== 4'h7 || frame !== 1'b1 || locked !== 1'b1 || err_fast !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_pair: both7seg=%04h hex=%h/%h frame=%b locked=%b err_fast=%b, required 2787 3/7 1 1 0",
               both7seg, hex_hi, hex_lo, frame, locked, err_fast);
    end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 8; i++) begin
      strobe(glyph_tab[2*i]);
      strobe(glyph_tab[2*i+1]);
      tests_run++;
      if (hex_hi !== 4'(2*i) || hex_lo !== 4'(2*i+1) || ok_hi !== 1'b1 || ok_lo !== 1'b1 || frame !== 1'b1) begin
        tests_failed++;
        $display("FAIL decode_%0d: hex=%h/%h ok=%b/%b frame=%b, required %h/%h 1/1 1",
                 i, hex_hi, hex_lo, ok_hi, ok_lo, frame, 4'(2*i), 4'(2*i+1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_stale();
    test_bad_glyph();
    test_err_fast();
    test_reset_mid();
    test_decode();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
